// File: rtl/req_rdy_rr_merge_pkg.sv
// Shared constants for the req/rdy merge blocks: default widths and a
// constant-evaluable ceil(log2) helper used to size ids, pointers and counters.
// No storage, no timing.
package req_rdy_rr_merge_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CH_NUM = 4;
  localparam int DEF_DEPTH  = 4;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/req_rdy_rr_merge_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last accepted grant.
// Latency: grant is combinational from req; the pointer moves on the edge after en.
// Backpressure: the pointer holds while en is low, so an unaccepted grant is offered again.
// Ports: clk/rst (async active-high), req[N] requests, en = grant was accepted,
//        grant[N] one-hot (zero when no request), grant_id = index of grant.
module rr_arbiter
  import req_rdy_rr_merge_pkg::*;
#(
  parameter  int N   = DEF_CH_NUM,
  localparam int IDW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] last;
  int             idx;
  logic           found;

  // Scan (last+1) .. (last+N) modulo N; the first hit wins, which places
  // the most recently served channel at the lowest priority.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx[IDW-1:0];
      end
    end
  end

  // Reset to N-1 so channel 0 is scanned first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= IDW'(N - 1);
    end else if (en) begin
      last <= grant_id;
    end
  end

endmodule

// File: rtl/req_rdy_rr_merge.sv
// Merges CH_NUM req/rdy producers into one req/rdy stream via round-robin into a DEPTH FIFO.
// Latency: a beat accepted in cycle N is presented at req_out in cycle N+1.
// Backpressure: all rdy_in drop while the FIFO is full, even in a cycle that pops.
// Ports: clk/rst (async active-high); req_in/rdy_in/data_in per-channel producer side
//        (channel i payload at data_in[i*DATA_W +: DATA_W]); req_out/rdy_out/data_out/id_out
//        consumer side; count = FIFO occupancy.
module req_rdy_rr_merge
  import req_rdy_rr_merge_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int CH_NUM = DEF_CH_NUM,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int ID_W   = clog2(CH_NUM),
  localparam int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        req_in,
  output logic [CH_NUM-1:0]        rdy_in,
  input  logic [CH_NUM*DATA_W-1:0] data_in,
  output logic                     req_out,
  input  logic                     rdy_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [ID_W-1:0]          id_out,
  output logic [CNT_W-1:0]         count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int ARB_W = clog2(CH_NUM);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ID_W-1:0]   mem_id   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [CH_NUM-1:0] grant;
  logic [ARB_W-1:0]  grant_id;
  logic [DATA_W-1:0] sel_data;
  logic              full;
  logic              push;
  logic              pop;

  rr_arbiter #(
    .N (CH_NUM)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_in),
    .en       (push),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign full = (count == CNT_W'(DEPTH));

  // Full is judged on the registered count only: a pop in the same cycle
  // does not free a slot until the next edge, so there is no pass-through.
  assign rdy_in   = (rst || full) ? '0 : grant;
  assign push     = |(req_in & rdy_in);
  assign pop      = req_out & rdy_out;
  assign sel_data = data_in[int'(grant_id) * DATA_W +: DATA_W];

  assign req_out  = (count != '0);
  assign data_out = mem_data[rd_ptr];
  assign id_out   = mem_id[rd_ptr];

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_id[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= sel_data;
        mem_id[wr_ptr]   <= ID_W'(grant_id);
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
